// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared widths and the illegal-access check for the data memory.
package data_mem_pkg;
   localparam int unsigned WORD_W     = 32;
   localparam int unsigned BYTE_OFF_W = 2;

   // Compare the word index rather than the byte address so depth*4 cannot overflow.
   function automatic logic is_illegal(input logic [WORD_W-1:0] addr, input int unsigned depth);
      return (addr[BYTE_OFF_W-1:0] != '0) || ({{BYTE_OFF_W{1'b0}}, addr[WORD_W-1:BYTE_OFF_W]} >= depth);
   endfunction
endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: single-port DEPTH x 32 RAM, sync write, registered read-first output.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter              INIT_FILE = "data_mem.hex",
  parameter logic [WORD_W-1:0] INIT_IMAGE [DEPTH] = '{default: '0}
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH];
`ifdef DATA_MEM_INIT_EN
  initial for (int i = 0; i < DEPTH; i++) mem[i] = INIT_IMAGE[i];
`endif
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= wdata;
    rdata <= mem[idx];
  end
endmodule

// File: rtl/data_memory.sv
// data_memory: word-organised data RAM with byte addressing and illegal-access flag.
module data_memory
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter              INIT_FILE = "data_mem.hex",
  parameter logic [WORD_W-1:0] INIT_IMAGE [DEPTH] = '{default: '0}
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [WORD_W-1:0] Data_address,
  input  logic [WORD_W-1:0] Data_in,
  input  logic              we,
  output logic [WORD_W-1:0] Data_out,
  output logic              Addr_err
);
  logic              ill;
  logic              out_en;
  logic [WORD_W-1:0] ram_q;
  assign ill = is_illegal(Data_address, DEPTH);
  data_mem_array #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_FILE(INIT_FILE), .INIT_IMAGE(INIT_IMAGE)) u_array (
    .clk   (Clk),
    .wr_en (we && !ill && !Reset),
    .idx   (Data_address[ADDR_W+1:BYTE_OFF_W]),
    .wdata (Data_in),
    .rdata (ram_q)
  );
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_en   <= 1'b0;
      Addr_err <= 1'b0;
    end else begin
      out_en   <= 1'b1;
      Addr_err <= ill;
    end
  end
  assign Data_out = (out_en && !Addr_err) ? ram_q : '0;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: scoreboard bench for data_memory against a reference word model.
module tb_data_memory;
  logic        clk_unused;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Data_address = '0;
  logic [31:0] Data_in = '0;
  logic        we = 1'b0;
  logic [31:0] Data_out;
  logic        Addr_err;
  typedef struct {
    string       tag;
    logic [31:0] d;
    logic        e;
  } exp_t;
  exp_t        sb [$];
  logic [31:0] model [int unsigned];
  int          n_checks = 0;
  int          n_fail = 0;
  data_memory #(.INIT_IMAGE('{0: 32'hCAFE_F00D, default: 32'h0})) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Data_address (Data_address),
    .Data_in      (Data_in),
    .we           (we),
    .Data_out     (Data_out),
    .Addr_err     (Addr_err)
  );
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drain();
    exp_t x;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      check({x.tag, "_data"}, Data_out, x.d);
      check({x.tag, "_err"}, {31'b0, Addr_err}, {31'b0, x.e});
    end
  endtask
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] d, input logic w);
    exp_t        x;
    logic        ill;
    int unsigned k;
    @(negedge Clk);
    drain();
    Data_address = a;
    Data_in      = d;
    we           = w;
    ill = (a[1:0] != 2'b00) || (a >= 32'h0000_0400);
    k   = int'(a[9:2]);
    x.tag = tag;
    x.e   = ill;
    x.d   = ill ? 32'h0 : (model.exists(k) ? model[k] : 32'hxxxx_xxxx);
    sb.push_back(x);
    if (w && !ill) model[k] = d;
  endtask
  initial begin
    logic [31:0] a;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_data", Data_out, 32'h0);
    check("rst_err", {31'b0, Addr_err}, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
`ifdef DATA_MEM_INIT_EN
    model[0] = 32'hCAFE_F00D;
    step("init_rd0", 32'h0, 32'h0, 1'b0);
`endif
    step("wr10", 32'h10, 32'hDEAD_BEEF, 1'b1);
    step("rd10", 32'h10, 32'h0, 1'b0);
    step("wr20a", 32'h20, 32'h1111_1111, 1'b1);
    step("rfw20", 32'h20, 32'h2222_2222, 1'b1);
    step("rd20", 32'h20, 32'h0, 1'b0);
    step("mis12", 32'h12, 32'hFFFF_FFFF, 1'b1);
    step("rd10b", 32'h10, 32'h0, 1'b0);
    step("oor400", 32'h400, 32'h5555_5555, 1'b1);
    step("oor410", 32'h410, 32'h6666_6666, 1'b1);
    step("oorhi", 32'h8000_0010, 32'h7777_7777, 1'b1);
    step("oorfc", 32'hFFFF_FFFC, 32'h8888_8888, 1'b1);
    step("rd10c", 32'h10, 32'h0, 1'b0);
    step("rd0c", 32'h0, 32'h0, 1'b0);
    step("wr3fc", 32'h3FC, 32'hA5A5_5A5A, 1'b1);
    step("rd3fc", 32'h3FC, 32'h0, 1'b0);
    step("rd00", 32'h00, 32'h0, 1'b0);
    for (int i = 0; i < 16; i++) step("fill", 32'(i * 4), $urandom, 1'b1);
    for (int i = 0; i < 300; i++) begin
      a = 32'($urandom_range(0, 15) * 4);
      case ($urandom_range(0, 7))
        0: a = a | 32'($urandom_range(1, 3));
        1: a = a | 32'h0000_0400;
        2: a = a | 32'h0100_0000;
        default: ;
      endcase
      step("soak", a, $urandom, 1'($urandom_range(0, 1)));
    end
    step("wr10r", 32'h10, 32'h1234_5678, 1'b1);
    step("rd10r", 32'h10, 32'h0, 1'b0);
    @(negedge Clk);
    drain();
    #2 Reset = 1'b1;
    #1;
    check("async_rst_data", Data_out, 32'h0);
    check("async_rst_err", {31'b0, Addr_err}, 32'h0);
    Data_address = 32'h10;
    Data_in      = 32'hBADB_AD00;
    we           = 1'b1;
    @(posedge Clk);
    #1;
    check("rst_hold_data", Data_out, 32'h0);
    check("rst_hold_err", {31'b0, Addr_err}, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    we    = 1'b0;
    step("rd10_after_rst", 32'h10, 32'h0, 1'b0);
    step("rd20_after_rst", 32'h20, 32'h0, 1'b0);
    step("mis_after_rst", 32'h22, 32'h0, 1'b0);
    @(negedge Clk);
    drain();
    we = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
